// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side issue/source bus of the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NB_REG_ADDR  = 5,
    parameter int NB_SEL       = 2,
    parameter int NB_LAT       = 2,
    parameter int NB_STALL_CNT = 32
);
    logic                    valid;
    logic [NB_REG_ADDR-1:0]  rs;
    logic [NB_REG_ADDR-1:0]  rt;
    logic                    use_rs;
    logic                    use_rt;
    logic                    issue;
    logic                    issue_we;
    logic [NB_REG_ADDR-1:0]  issue_rd;
    logic [NB_LAT-1:0]       issue_lat;
    logic                    flush;
    logic                    stall;
    logic [NB_SEL-1:0]       fwd_a;
    logic [NB_SEL-1:0]       fwd_b;
    logic [NB_STALL_CNT-1:0] stall_count;

    modport master (
        output valid, rs, rt, use_rs, use_rt, issue, issue_we, issue_rd, issue_lat, flush,
        input  stall, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  valid, rs, rt, use_rs, use_rt, issue, issue_we, issue_rd, issue_lat, flush,
        output stall, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer tracker driving forward selects, decode stall and stall count
module hazard_scoreboard #(
    parameter int NB_REG_ADDR  = 5,
    parameter int N_FWD_STAGES = 3,
    parameter int NB_SEL       = 2,
    parameter int NB_LAT       = 2,
    parameter int NB_STALL_CNT = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    hazard_scoreboard_if.slave bus
);
    logic                   slot_valid [N_FWD_STAGES];
    logic [NB_REG_ADDR-1:0] slot_rd    [N_FWD_STAGES];
    logic [NB_LAT-1:0]      slot_rem   [N_FWD_STAGES];

    logic                    pend_a;
    logic                    pend_b;
    logic [NB_SEL-1:0]       sel_a;
    logic [NB_SEL-1:0]       sel_b;
    logic                    stall;
    logic                    insert;
    logic [NB_LAT-1:0]       lat_eff;
    logic [NB_STALL_CNT-1:0] stall_count;

    // Walk oldest to youngest so the youngest matching writer has the final say.
    always_comb begin
        pend_a = 1'b0;
        sel_a  = '0;
        pend_b = 1'b0;
        sel_b  = '0;
        for (int k = N_FWD_STAGES - 1; k >= 0; k--) begin
            if (slot_valid[k] && slot_rd[k] == bus.rs) begin
                pend_a = (slot_rem[k] != '0);
                sel_a  = (slot_rem[k] == '0) ? NB_SEL'(k + 1) : '0;
            end
            if (slot_valid[k] && slot_rd[k] == bus.rt) begin
                pend_b = (slot_rem[k] != '0);
                sel_b  = (slot_rem[k] == '0) ? NB_SEL'(k + 1) : '0;
            end
        end
        if (!bus.use_rs || bus.rs == '0) begin
            pend_a = 1'b0;
            sel_a  = '0;
        end
        if (!bus.use_rt || bus.rt == '0) begin
            pend_b = 1'b0;
            sel_b  = '0;
        end
    end

    always_comb begin
        lat_eff = bus.issue_lat;
        if (bus.issue_lat == '0) begin
            lat_eff = NB_LAT'(1);
        end else if (int'(bus.issue_lat) > N_FWD_STAGES) begin
            lat_eff = NB_LAT'(N_FWD_STAGES);
        end
    end

    assign stall  = (pend_a || pend_b) && !bus.flush;
    assign insert = bus.issue && bus.issue_we && !stall && !bus.flush && (bus.issue_rd != '0);

    assign bus.stall       = stall;
    assign bus.fwd_a       = sel_a;
    assign bus.fwd_b       = sel_b;
    assign bus.stall_count = stall_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < N_FWD_STAGES; k++) begin
                slot_valid[k] <= 1'b0;
                slot_rd[k]    <= '0;
                slot_rem[k]   <= '0;
            end
            stall_count <= '0;
        end else if (bus.valid) begin
            // The last slot simply falls off: the regfile is write-first.
            for (int k = N_FWD_STAGES - 1; k >= 1; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_rd[k]    <= slot_rd[k-1];
                slot_rem[k]   <= (slot_rem[k-1] == '0) ? '0 : slot_rem[k-1] - NB_LAT'(1);
            end
            slot_valid[0] <= insert;
            slot_rd[0]    <= insert ? bus.issue_rd : '0;
            slot_rem[0]   <= insert ? lat_eff - NB_LAT'(1) : '0;
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + NB_STALL_CNT'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard with a narrow stall counter
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [8:0] exp_q [$];

    hazard_scoreboard_if #(.NB_REG_ADDR(5), .NB_SEL(2), .NB_LAT(2), .NB_STALL_CNT(4)) bus ();

    hazard_scoreboard #(
        .NB_REG_ADDR(5), .N_FWD_STAGES(3), .NB_SEL(2), .NB_LAT(2), .NB_STALL_CNT(4)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] mk(input logic s, input logic [1:0] a, input logic [1:0] b, input logic [3:0] c);
        return {s, a, b, c};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.stall, bus.fwd_a, bus.fwd_b, bus.stall_count};
    endfunction

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic urs, input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                       input logic iss, input logic [4:0] rd, input logic [1:0] lat, input logic fl);
        bus.valid     = v;
        bus.use_rs    = urs;
        bus.rs        = rs;
        bus.use_rt    = urt;
        bus.rt        = rt;
        bus.issue     = iss;
        bus.issue_we  = iss;
        bus.issue_rd  = rd;
        bus.issue_lat = lat;
        bus.flush     = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got, e;
        rst_n = 1'b0;
        drv(1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 2'd1, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL reset_now got=%h exp=%h", got, e); end
        tick();
        tick();
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_chain();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd3, 2'd1, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL alu_issue got=%h exp=%h", got, e); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            drv(1, 1, 5'd3, 0, 0, 0, 0, 0, 0);
            exp_q.push_back(mk(0, (k <= 3) ? 2'(k) : 2'd0, 0, 0));
            #2; got = obs(); e = exp_q.pop_front(); n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL alu_fwd_step%0d got=%h exp=%h", k, got, e); end
        end
    endtask

    task automatic test_load_use();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 2'd2, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lw_issue got=%h exp=%h", got, e); end
        tick();
        drv(1, 0, 0, 1, 5'd5, 1, 5'd6, 2'd1, 0);
        exp_q.push_back(mk(1, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lw_use_stall got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(mk(0, 0, 2, 1));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lw_use_fwd got=%h exp=%h", got, e); end
        tick();
        drv(1, 1, 5'd6, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 1, 0, 1));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lw_after_stall got=%h exp=%h", got, e); end
    endtask

    task automatic test_shadowing();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd4, 2'd1, 0);
        tick();
        drv(1, 1, 5'd4, 0, 0, 1, 5'd4, 2'd0, 0);
        exp_q.push_back(mk(0, 1, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL shadow_first got=%h exp=%h", got, e); end
        tick();
        drv(1, 1, 5'd4, 1, 5'd4, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 1, 1, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL shadow_youngest got=%h exp=%h", got, e); end
        tick();
        drv(1, 1, 5'd4, 1, 5'd4, 1, 5'd7, 2'd1, 0);
        exp_q.push_back(mk(0, 2, 2, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL shadow_shifted got=%h exp=%h", got, e); end
        tick();
        drv(1, 0, 0, 0, 0, 1, 5'd7, 2'd2, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL shadow_idle got=%h exp=%h", got, e); end
        tick();
        drv(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL shadow_pending_young got=%h exp=%h", got, e); end
    endtask

    task automatic test_r0_unused();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd0, 2'd1, 0);
        tick();
        drv(1, 1, 5'd0, 1, 5'd0, 1, 5'd9, 2'd2, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL r0_source got=%h exp=%h", got, e); end
        tick();
        drv(1, 0, 5'd9, 0, 5'd9, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL unused_operands got=%h exp=%h", got, e); end
        drv(1, 1, 5'd9, 0, 5'd9, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL used_operand got=%h exp=%h", got, e); end
    endtask

    task automatic test_flush_freeze();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 2'd2, 0);
        tick();
        drv(1, 0, 0, 1, 5'd5, 1, 5'd8, 2'd1, 1);
        exp_q.push_back(mk(0, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL flush_no_stall got=%h exp=%h", got, e); end
        tick();
        drv(1, 1, 5'd8, 1, 5'd5, 1, 5'd10, 2'd2, 0);
        exp_q.push_back(mk(0, 0, 2, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL flush_bubble got=%h exp=%h", got, e); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drv(0, 1, 5'd10, 1, 5'd5, 0, 0, 0, 0);
            exp_q.push_back(mk(1, 0, 3, 0));
            #2; got = obs(); e = exp_q.pop_front(); n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL freeze_cycle%0d got=%h exp=%h", k, got, e); end
            tick();
        end
        drv(1, 1, 5'd10, 1, 5'd5, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 3, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL freeze_release got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(mk(0, 2, 0, 1));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL freeze_step got=%h exp=%h", got, e); end
    endtask

    task automatic test_async_reset_saturate();
        logic [8:0] got, e;
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5'd5, 2'd3, 0);
        tick();
        drv(1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lat3_stall got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(mk(1, 0, 0, 1));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL lat3_stall2 got=%h exp=%h", got, e); end
        #1 rst_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", got, e); end
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 0, 0, 0, 1, 5'd5, 2'd3, 0);
            exp_q.push_back(mk(0, 0, 0, sat(2 * i)));
            #2; got = obs(); e = exp_q.pop_front(); n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL sat_issue%0d got=%h exp=%h", i, got, e); end
            tick();
            drv(1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
            exp_q.push_back(mk(1, 0, 0, sat(2 * i)));
            #2; got = obs(); e = exp_q.pop_front(); n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL sat_stall%0d got=%h exp=%h", i, got, e); end
            tick();
            tick();
        end
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 4'd15));
        #2; got = obs(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL sat_final got=%h exp=%h", got, e); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_shadowing();
        test_r0_unused();
        test_flush_freeze();
        test_async_reset_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
